// File: rtl/pkt_port_top.sv
// Store-and-forward output-port packet queue: accepts addressed/broadcast packets,
// commits them whole, rolls back overflowing packets and serves complete packets only.
module pkt_port_top #(
  parameter int                   FIFO_SIZE  = 64,
  parameter int                   W_WIDTH    = 8,
  parameter bit                   BCAST_EN   = 1'b1,
  parameter logic [W_WIDTH-1:0]   BCAST_ADDR = {W_WIDTH{1'b1}},
  parameter int                   CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_en,
  input  logic [W_WIDTH-1:0] port_data,
  input  logic [W_WIDTH-1:0] port_addr,
  output logic               rd_out,
  input  logic               port_rd,
  output logic [W_WIDTH-1:0] port_out,
  output logic               port_eop,
  output logic               port_rdy,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int AW    = $clog2(FIFO_SIZE);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(FIFO_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rd_ptr, commit_ptr, shadow_ptr, last_ptr;
  logic [W_WIDTH-1:0] mem [FIFO_SIZE];
  logic [FIFO_SIZE-1:0] eop_bits;
  logic               full, da_match, head_eop, pop, eop_pop;
  logic               wr_en, do_commit, rollback, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
  endfunction

  // Occupancy is measured against the shadow pointer so a partial packet reserves space.
  assign full     = (shadow_ptr - rd_ptr) == FULL_LVL;
  assign rd_out   = !full;
  assign last_ptr = shadow_ptr - PTR_ONE;
  assign da_match = (port_data == port_addr) || (BCAST_EN && (port_data == BCAST_ADDR));
  assign port_rdy = (pkt_cnt != '0);
  assign head_eop = eop_bits[rd_ptr[AW-1:0]];
  assign port_out = port_rdy ? mem[rd_ptr[AW-1:0]] : '0;
  assign port_eop = port_rdy & head_eop;
  assign pop      = port_rd & port_rdy;
  assign eop_pop  = pop & head_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    do_commit = 1'b0;
    rollback  = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (sw_en) begin
          if (da_match && !full) begin
            wr_en     = 1'b1;
            state_nxt = ACCEPT;
          end else begin
            drop      = da_match;
            state_nxt = DISCARD;
          end
        end
      end
      ACCEPT: begin
        if (!sw_en) begin
          do_commit = 1'b1;
          state_nxt = IDLE;
        end else if (full) begin
          rollback  = 1'b1;
          drop      = 1'b1;
          state_nxt = DISCARD;
        end else begin
          wr_en = 1'b1;
        end
      end
      DISCARD: begin
        if (!sw_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat storage carries no reset; visibility is gated by pkt_cnt and the eop bits.
  always_ff @(posedge clk) begin
    if (wr_en) mem[shadow_ptr[AW-1:0]] <= port_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      commit_ptr <= '0;
      shadow_ptr <= '0;
      eop_bits   <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (pop) begin
        rd_ptr                     <= rd_ptr + PTR_ONE;
        eop_bits[rd_ptr[AW-1:0]]   <= 1'b0;
      end
      if (wr_en)         shadow_ptr <= shadow_ptr + PTR_ONE;
      else if (rollback) shadow_ptr <= commit_ptr;
      // The commit slot is uncommitted, so it never collides with the popped slot.
      if (do_commit) begin
        commit_ptr                 <= shadow_ptr;
        eop_bits[last_ptr[AW-1:0]] <= 1'b1;
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
      case ({do_commit, eop_pop})
        2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule
